// File: rtl/present_slayer_serial_3sh.sv
// present_slayer_serial_3sh: PRESENT S-box layer on a 3-share masked state.
// The 64-bit state is pushed one nibble per cycle through an external
// masked S-box pipeline and reassembled from its outputs.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   st_in1..3   [63:0]       input state shares, sampled when start is seen in IDLE
//   start                    run request, ignored unless IDLE
//   sb_in1..3   [3:0]        registered share nibbles towards the S-box pipeline
//   sb_out1..3  [3:0]        share nibbles returned SBOX_LAT cycles later
//   st_out1..3  [63:0]       registered substituted shares, updated with done
//   busy                     high during FEED and DRAIN
//   done                     one-cycle completion pulse
//
// Timing: start is seen in cycle 0. Nibble k is on sb_in* in cycle k+1,
// its result is captured in cycle k+1+SBOX_LAT, and done is high in cycle
// 17+SBOX_LAT. The next start can be taken one cycle later.
//
// Optional macro SLAYER_IDLE_FLUSH_EN: sb_in* is forced to zero when no
// nibble is being issued. Without the macro, sb_in* holds the last issued
// nibble.

module present_slayer_serial_3sh #(
  parameter int SBOX_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] st_in1,
  input  logic [63:0] st_in2,
  input  logic [63:0] st_in3,
  input  logic        start,
  output logic [3:0]  sb_in1,
  output logic [3:0]  sb_in2,
  output logic [3:0]  sb_in3,
  input  logic [3:0]  sb_out1,
  input  logic [3:0]  sb_out2,
  input  logic [3:0]  sb_out3,
  output logic [63:0] st_out1,
  output logic [63:0] st_out2,
  output logic [63:0] st_out3,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, FIN} state_t;

  state_t              state;
  // Nibble 0 goes straight from st_in* to sb_in*. The feed registers only
  // hold nibbles 1..15, and the next nibble to issue is always at [3:0].
  logic [59:0]         feed1, feed2, feed3;
  // Nibbles 0..14 are collected here. The 16th nibble is combined with them
  // directly when st_out* is loaded, so st_out* changes only at done.
  logic [59:0]         acc1, acc2, acc3;
  logic [3:0]          iss_cnt;
  logic [3:0]          col_cnt;
  logic [SBOX_LAT-1:0] vld_dl;
  logic                cap;

  // The nibble issued in the cycle that this bit was loaded is now on sb_out*.
  assign cap = vld_dl[SBOX_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      feed1   <= '0;
      feed2   <= '0;
      feed3   <= '0;
      acc1    <= '0;
      acc2    <= '0;
      acc3    <= '0;
      iss_cnt <= '0;
      col_cnt <= '0;
      vld_dl  <= '0;
      sb_in1  <= '0;
      sb_in2  <= '0;
      sb_in3  <= '0;
      st_out1 <= '0;
      st_out2 <= '0;
      st_out3 <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;

      // A nibble is valid on sb_in* exactly while the state is FEED.
      vld_dl[0] <= (state == FEED);
      for (int i = 1; i < SBOX_LAT; i++) begin
        vld_dl[i] <= vld_dl[i-1];
      end

      // Capture can begin while still in FEED when SBOX_LAT is small.
      if (cap) begin
        acc1    <= {sb_out1, acc1[59:4]};
        acc2    <= {sb_out2, acc2[59:4]};
        acc3    <= {sb_out3, acc3[59:4]};
        col_cnt <= col_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            feed1   <= st_in1[63:4];
            feed2   <= st_in2[63:4];
            feed3   <= st_in3[63:4];
            sb_in1  <= st_in1[3:0];
            sb_in2  <= st_in2[3:0];
            sb_in3  <= st_in3[3:0];
            iss_cnt <= 4'd0;
            busy    <= 1'b1;
            state   <= FEED;
          end
        end

        FEED: begin
          // iss_cnt is the index of the nibble currently on sb_in*.
          if (iss_cnt == 4'd15) begin
            iss_cnt <= 4'd0;
            state   <= DRAIN;
`ifdef SLAYER_IDLE_FLUSH_EN
            // Stays zero through DRAIN, FIN and IDLE until the next issue.
            sb_in1  <= 4'h0;
            sb_in2  <= 4'h0;
            sb_in3  <= 4'h0;
`endif
          end else begin
            sb_in1  <= feed1[3:0];
            sb_in2  <= feed2[3:0];
            sb_in3  <= feed3[3:0];
            feed1   <= {4'h0, feed1[59:4]};
            feed2   <= {4'h0, feed2[59:4]};
            feed3   <= {4'h0, feed3[59:4]};
            iss_cnt <= iss_cnt + 4'd1;
          end
        end

        DRAIN: begin
          if (cap && (col_cnt == 4'd15)) begin
            st_out1 <= {sb_out1, acc1};
            st_out2 <= {sb_out2, acc2};
            st_out3 <= {sb_out3, acc3};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FIN;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_slayer_serial_3sh.sv
// Testbench for present_slayer_serial_3sh. A masked S-box pipeline model
// re-randomises the output shares of every nibble. Expected results are
// queued when a run starts and checked by a separate monitor at done.

module tb_present_slayer_serial_3sh;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic [63:0] st_in1, st_in2, st_in3;
  logic        start;
  logic [3:0]  sb_in1, sb_in2, sb_in3;
  logic [3:0]  sb_out1, sb_out2, sb_out3;
  logic [63:0] st_out1, st_out2, st_out3;
  logic        busy, done;

  present_slayer_serial_3sh #(.SBOX_LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .st_in1  (st_in1),
    .st_in2  (st_in2),
    .st_in3  (st_in3),
    .start   (start),
    .sb_in1  (sb_in1),
    .sb_in2  (sb_in2),
    .sb_in3  (sb_in3),
    .sb_out1 (sb_out1),
    .sb_out2 (sb_out2),
    .sb_out3 (sb_out3),
    .st_out1 (st_out1),
    .st_out2 (st_out2),
    .st_out3 (st_out3),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;  // S(x) = tbl[4x+3:4x]
    return tbl[4*x +: 4];
  endfunction

  function automatic logic [63:0] layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = sbox(s[4*k +: 4]);
    return r;
  endfunction

  // External masked S-box: input is unmasked only here, and the output is
  // re-split with fresh randomness. The result appears LAT cycles after input.
  logic [3:0] p1 [LAT];
  logic [3:0] p2 [LAT];
  logic [3:0] p3 [LAT];
  logic [3:0] sy, r1, r2;
  always @(posedge clk) begin
    sy = sbox(sb_in1 ^ sb_in2 ^ sb_in3);
    r1 = 4'($urandom);
    r2 = 4'($urandom);
    p1[0] <= r1;
    p2[0] <= r2;
    p3[0] <= sy ^ r1 ^ r2;
    for (int i = 1; i < LAT; i++) begin
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
      p3[i] <= p3[i-1];
    end
  end
  assign sb_out1 = p1[LAT-1];
  assign sb_out2 = p2[LAT-1];
  assign sb_out3 = p3[LAT-1];

  // Scoreboard queues are filled at start and emptied by the monitor.
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [63:0] hold_exp = '0;
  logic [63:0] e_res;
  int          e_cyc;
  logic        rst_q = 1'b0;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_q) begin
        exp_q.delete();
        exp_cyc_q.delete();
        hold_exp = '0;
        chk("done_after_rst", {63'd0, done}, 64'd0);
        chk("st_out_after_rst", st_out1 ^ st_out2 ^ st_out3, 64'd0);
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e_res = exp_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          chk("result", st_out1 ^ st_out2 ^ st_out3, e_res);
          chk("done_cycle", 64'(cyc), 64'(e_cyc));
          hold_exp = e_res;
        end
      end else begin
        chk("st_out_hold", st_out1 ^ st_out2 ^ st_out3, hold_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run. The task returns in the first IDLE cycle after FIN
  // (relative cycle 18+LAT), so a following call starts back-to-back.
  task automatic run(input logic [63:0] st, input bit hold_start);
    logic [63:0] s1, s2, s3;
    logic [11:0] last;
    s1 = {$urandom, $urandom};
    s2 = {$urandom, $urandom};
    s3 = st ^ s1 ^ s2;
    st_in1 = s1;
    st_in2 = s2;
    st_in3 = s3;
    start  = 1'b1;
    exp_q.push_back(layer(st));
    exp_cyc_q.push_back(cyc + 17 + LAT);
    last = {s1[63:60], s2[63:60], s3[63:60]};
    for (int rel = 1; rel <= 17 + LAT; rel++) begin
      tick();
      if (!hold_start) start = 1'b0;
      chk("busy", {63'd0, busy}, {63'd0, (rel <= 16 + LAT)});
      if (rel <= 16) begin
        chk("sb_in_feed", {52'd0, sb_in1, sb_in2, sb_in3},
            {52'd0, s1[4*(rel-1) +: 4], s2[4*(rel-1) +: 4], s3[4*(rel-1) +: 4]});
      end else if (rel == 17) begin
`ifdef SLAYER_IDLE_FLUSH_EN
        chk("sb_in_drain", {52'd0, sb_in1, sb_in2, sb_in3}, 64'd0);
`else
        chk("sb_in_drain", {52'd0, sb_in1, sb_in2, sb_in3}, {52'd0, last});
`endif
      end
    end
    tick();
`ifdef SLAYER_IDLE_FLUSH_EN
    chk("sb_in_idle", {52'd0, sb_in1, sb_in2, sb_in3}, 64'd0);
`else
    chk("sb_in_idle", {52'd0, sb_in1, sb_in2, sb_in3}, {52'd0, last});
`endif
  endtask

  task automatic gap(input int n);
    start = 1'b0;
    repeat (n) tick();
  endtask

  // Start a run, assert rst in its cycle 9, and check that it is aborted.
  task automatic run_abort(input logic [63:0] st);
    st_in1 = {$urandom, $urandom};
    st_in2 = {$urandom, $urandom};
    st_in3 = st ^ st_in1 ^ st_in2;
    start  = 1'b1;
    exp_q.push_back(layer(st));
    exp_cyc_q.push_back(cyc + 17 + LAT);
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_st_out1", st_out1, 64'd0);
    chk("abort_st_out2", st_out2, 64'd0);
    chk("abort_st_out3", st_out3, 64'd0);
    repeat (25) tick();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    st_in1 = '0;
    st_in2 = '0;
    st_in3 = '0;
    repeat (3) tick();
    chk("rst_sb_in", {52'd0, sb_in1, sb_in2, sb_in3}, 64'd0);
    chk("rst_st_out1", st_out1, 64'd0);
    chk("rst_st_out2", st_out2, 64'd0);
    chk("rst_st_out3", st_out3, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    tick();

    // Known vectors: all-zero, counting pattern, all-ones.
    run(64'h0000000000000000, 1'b0);
    gap(2);
    run(64'h0123456789ABCDEF, 1'b0);
    gap(1);
    run(64'hFFFFFFFFFFFFFFFF, 1'b0);

    // Hold start high so the second run is accepted right after FIN.
    run({$urandom, $urandom}, 1'b1);
    run({$urandom, $urandom}, 1'b0);
    gap(3);

    // Abort a run with reset, then make sure the next run is correct.
    run_abort({$urandom, $urandom});
    run(64'h0123456789ABCDEF, 1'b0);

    for (int t = 0; t < 8; t++) begin
      gap($urandom_range(0, 3));
      run({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    gap(30);
    chk("pending_results", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
